// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage.
// Captures EX/MEM results and control for writeback and waits on a
// variable-latency data-memory read response for loads. While a load is
// outstanding, the stage stalls upstream and keeps the captured
// control/address in hold registers. A response that never arrives is
// completed after TIMEOUT wait cycles. The write is then suppressed and a
// sticky error flag is raised.
module mem_wb_stage #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_MemRead,
  input  logic              ex_MemtoReg,
  input  logic              ex_RegWrite,
  input  logic [4:0]        ex_Rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic [4:0]        wb_Rd,
  output logic [DATA_W-1:0] dm_read_data,
  output logic [DATA_W-1:0] dm_address,
  output logic              mem_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [4:0]       RD_XZR    = 5'd31;

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;

  logic                hold_memtoreg_r, hold_memtoreg_nxt_s;
  logic                hold_regwrite_r, hold_regwrite_nxt_s;
  logic [4:0]          hold_rd_r, hold_rd_nxt_s;
  logic [DATA_W-1:0]   hold_addr_r, hold_addr_nxt_s;

  logic                wb_valid_r, wb_valid_nxt_s;
  logic                memtoreg_r, memtoreg_nxt_s;
  logic                regwrite_r, regwrite_nxt_s;
  logic [4:0]          wb_rd_r, wb_rd_nxt_s;
  logic [DATA_W-1:0]   rdata_r, rdata_nxt_s;
  logic [DATA_W-1:0]   addr_r, addr_nxt_s;
  logic                mem_err_r, mem_err_nxt_s;

  // Register writes to XZR are dropped at capture time.
  logic                ex_wr_en_s;
  assign ex_wr_en_s = ex_RegWrite & (ex_Rd != RD_XZR);

  // Stall while a load is issued without data or still waiting short of timeout.
  assign mem_stall = reset &
                     (((state_r == ST_IDLE) & ex_valid & ex_MemRead & ~dm_rvalid) |
                      ((state_r == ST_WAIT) & ~dm_rvalid & (cnt_r != TIMEOUT_C)));

  // Next-state and next-output logic. Flush overrides every other transition.
  always_comb begin
    state_nxt_s         = state_r;
    cnt_nxt_s           = cnt_r;
    hold_memtoreg_nxt_s = hold_memtoreg_r;
    hold_regwrite_nxt_s = hold_regwrite_r;
    hold_rd_nxt_s       = hold_rd_r;
    hold_addr_nxt_s     = hold_addr_r;
    wb_valid_nxt_s      = 1'b0;
    regwrite_nxt_s      = 1'b0;
    memtoreg_nxt_s      = memtoreg_r;
    wb_rd_nxt_s         = wb_rd_r;
    rdata_nxt_s         = rdata_r;
    addr_nxt_s          = addr_r;
    mem_err_nxt_s       = mem_err_r;

    if (flush) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ex_valid && !ex_MemRead) begin
            memtoreg_nxt_s = ex_MemtoReg;
            regwrite_nxt_s = ex_wr_en_s;
            wb_rd_nxt_s    = ex_Rd;
            addr_nxt_s     = ex_alu_result;
            rdata_nxt_s    = {DATA_W{1'b0}};
            wb_valid_nxt_s = 1'b1;
          end else if (ex_valid && dm_rvalid) begin
            memtoreg_nxt_s = ex_MemtoReg;
            regwrite_nxt_s = ex_wr_en_s;
            wb_rd_nxt_s    = ex_Rd;
            addr_nxt_s     = ex_alu_result;
            rdata_nxt_s    = dm_rdata;
            wb_valid_nxt_s = 1'b1;
          end else if (ex_valid) begin
            hold_memtoreg_nxt_s = ex_MemtoReg;
            hold_regwrite_nxt_s = ex_wr_en_s;
            hold_rd_nxt_s       = ex_Rd;
            hold_addr_nxt_s     = ex_alu_result;
            cnt_nxt_s           = CNT_ONE;
            state_nxt_s         = ST_WAIT;
          end else begin
            wb_valid_nxt_s = 1'b0;
          end
        end
        ST_WAIT: begin
          if (dm_rvalid) begin
            memtoreg_nxt_s = hold_memtoreg_r;
            regwrite_nxt_s = hold_regwrite_r;
            wb_rd_nxt_s    = hold_rd_r;
            addr_nxt_s     = hold_addr_r;
            rdata_nxt_s    = dm_rdata;
            wb_valid_nxt_s = 1'b1;
            cnt_nxt_s      = CNT_ZERO;
            state_nxt_s    = ST_IDLE;
          end else if (cnt_r == TIMEOUT_C) begin
            memtoreg_nxt_s = hold_memtoreg_r;
            regwrite_nxt_s = 1'b0;
            wb_rd_nxt_s    = hold_rd_r;
            addr_nxt_s     = hold_addr_r;
            rdata_nxt_s    = {DATA_W{1'b0}};
            wb_valid_nxt_s = 1'b1;
            mem_err_nxt_s  = 1'b1;
            cnt_nxt_s      = CNT_ZERO;
            state_nxt_s    = ST_IDLE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Hold registers for an outstanding load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_memtoreg_r <= 1'b0;
      hold_regwrite_r <= 1'b0;
      hold_rd_r       <= 5'd0;
      hold_addr_r     <= {DATA_W{1'b0}};
    end else begin
      hold_memtoreg_r <= hold_memtoreg_nxt_s;
      hold_regwrite_r <= hold_regwrite_nxt_s;
      hold_rd_r       <= hold_rd_nxt_s;
      hold_addr_r     <= hold_addr_nxt_s;
    end
  end

  // Writeback output registers and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_r <= 1'b0;
      memtoreg_r <= 1'b0;
      regwrite_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      rdata_r    <= {DATA_W{1'b0}};
      addr_r     <= {DATA_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      wb_valid_r <= wb_valid_nxt_s;
      memtoreg_r <= memtoreg_nxt_s;
      regwrite_r <= regwrite_nxt_s;
      wb_rd_r    <= wb_rd_nxt_s;
      rdata_r    <= rdata_nxt_s;
      addr_r     <= addr_nxt_s;
      mem_err_r  <= mem_err_nxt_s;
    end
  end

  assign wb_valid     = wb_valid_r;
  assign MemtoReg     = memtoreg_r;
  assign RegWrite     = regwrite_r;
  assign wb_Rd        = wb_rd_r;
  assign dm_read_data = rdata_r;
  assign dm_address   = addr_r;
  assign mem_err      = mem_err_r;

endmodule
